// File: rtl/prog_loader_if.sv
// prog_loader_if: serial host link into the loader and the programming port it drives.
interface prog_loader_if;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       prog_enable;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       busy;
  logic       done;
  logic       error;
  modport master (
    output sck, cs_n, mosi,
    input  prog_enable, prog_data, prog_valid, busy, done, error
  );
  modport slave (
    input  sck, cs_n, mosi,
    output prog_enable, prog_data, prog_valid, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a framed, checksummed program image over a 3-wire serial link
// and replays it byte by byte onto the controller's programming port.
module prog_loader #(
  parameter int         PROG_BYTES = 32,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input logic          clock,
  input logic          rst_n,
  prog_loader_if.slave bus
);
  localparam int BW = $clog2(PROG_BYTES + 1);
  localparam logic [BW-1:0] LAST = BW'(PROG_BYTES);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHECK, WAIT_END, ERR} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sck_q, cs_q;
  logic [1:0]    mosi_q;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]    xor_q, xor_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          sck_rise, cs_fall, cs_rise, sck_ok, byte_done;
  logic [7:0]    byte_w;

  // Sync flops clear to 0 so a cs_n already low at reset release never looks like a new frame.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], bus.sck};
      cs_q   <= {cs_q[1:0], bus.cs_n};
      mosi_q <= {mosi_q[0], bus.mosi};
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign sck_ok    = sck_rise & ~cs_q[1];
  assign byte_w    = {sr_q[6:0], mosi_q[1]};
  assign byte_done = sck_ok & (bit_q == 3'd7);
  assign cnt_inc   = cnt_q + 1'b1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      data_q  <= data_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    xor_d   = xor_q;
    cnt_d   = cnt_q;
    sr_d    = sck_ok ? byte_w : sr_q;
    bit_d   = cs_fall ? 3'd0 : sck_ok ? bit_q + 3'd1 : bit_q;
    case (state_q)
      IDLE, ERR: if (cs_fall) begin
        state_d = HDR;
        xor_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      HDR: if (cs_rise) state_d = ERR;
        else if (byte_done) begin
          state_d = byte_w == HEADER ? PAYLOAD : ERR;
          en_d    = en_q | (byte_w == HEADER);
        end
      PAYLOAD: if (cs_rise) state_d = ERR;
        else if (byte_done) begin
          data_d  = byte_w;
          valid_d = 1'b1;
          xor_d   = xor_q ^ byte_w;
          cnt_d   = cnt_inc;
          state_d = cnt_inc == LAST ? CHECK : PAYLOAD;
        end
      CHECK: if (cs_rise) state_d = ERR;
        else if (byte_done) state_d = byte_w == xor_q ? WAIT_END : ERR;
      WAIT_END: if (cs_rise) begin
          state_d = IDLE;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end else if (sck_ok) state_d = ERR;
      default: state_d = IDLE;
    endcase
    // A failed frame keeps prog_enable as it was, so a half-loaded controller stays parked.
    if (state_d == ERR) err_d = 1'b1;
  end

  assign bus.prog_enable = en_q;
  assign bus.prog_data   = data_q;
  assign bus.prog_valid  = valid_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames scored against a frame-level model of the loader.
module tb_prog_loader;
  localparam int PB = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  prog_loader_if bus();
  prog_loader #(.PROG_BYTES(PB), .HEADER(HDR)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];
  int done_n = 0;

  always @(negedge clock) begin
    if (bus.prog_valid) got_q.push_back(bus.prog_data);
    if (bus.done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    bus.mosi = b;
    wait_clk($urandom_range(4, 7));
    bus.sck = 1'b1;
    wait_clk($urandom_range(4, 7));
    bus.sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  logic [7:0] fr[$];
  int         extra;
  logic       model_en, new_en, exp_err, exp_done, exp_acc;
  logic [7:0] exp_v[$];
  logic [7:0] last_data;

  // Frame-level view: which payload bytes get delivered and how the frame ends.
  function automatic void model();
    logic [7:0] x;
    x = 8'h00;
    exp_v.delete();
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_acc  = 1'b0;
    if (fr.size() > 0 && fr[0] == HDR) begin
      exp_acc = 1'b1;
      for (int i = 1; i < fr.size() && i <= PB; i++) begin
        exp_v.push_back(fr[i]);
        x ^= fr[i];
      end
      if (fr.size() == PB + 2 && extra == 0 && fr[PB+1] == x) begin
        exp_err  = 1'b0;
        exp_done = 1'b1;
      end
    end
    new_en = exp_acc ? !exp_done : model_en;
    if (exp_v.size() > 0) last_data = exp_v[exp_v.size()-1];
  endfunction

  task automatic run_frame(input string tag);
    model();
    got_q.delete();
    done_n = 0;
    bus.cs_n = 1'b0;
    wait_clk(5);
    foreach (fr[i]) send_byte(fr[i]);
    repeat (extra) send_bit(1'($urandom_range(0, 1)));
    wait_clk(6);
    chk({tag, "_en_mid"}, bus.prog_enable, exp_acc ? 1'b1 : model_en);
    bus.cs_n = 1'b1;
    wait_clk(8);
    model_en = new_en;
    chk({tag, "_err"}, bus.error, exp_err);
    chk({tag, "_en"}, bus.prog_enable, model_en);
    chk({tag, "_done"}, done_n, exp_done);
    chk({tag, "_busy"}, bus.busy, exp_err);
    chk({tag, "_nvalid"}, got_q.size(), exp_v.size());
    for (int i = 0; i < got_q.size() && i < exp_v.size(); i++) chk({tag, "_data"}, got_q[i], exp_v[i]);
    chk({tag, "_hold"}, bus.prog_data, last_data);
    wait_clk(2);
  endtask

  task automatic good_frame(input logic [7:0] p0, p1, p2, p3);
    fr = '{HDR, p0, p1, p2, p3, p0 ^ p1 ^ p2 ^ p3};
    extra = 0;
  endtask

  initial begin
    logic [7:0] p[4];
    bus.sck = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    model_en = 1'b0;
    last_data = 8'h00;
    wait_clk(3);
    chk("rst_en", bus.prog_enable, 0);
    chk("rst_data", bus.prog_data, 0);
    chk("rst_valid", bus.prog_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.error, 0);
    rst_n = 1'b1;
    wait_clk(4);

    good_frame(8'h01, 8'h02, 8'h04, 8'h08);
    run_frame("good");
    fr = '{8'h5A};
    extra = 0;
    run_frame("badhdr");
    good_frame(8'h11, 8'h22, 8'h33, 8'h44);
    run_frame("recover");
    fr = '{HDR, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00};
    extra = 0;
    run_frame("badsum");
    fr = '{HDR, 8'h01};
    extra = 3;
    run_frame("trunc");
    good_frame(8'h01, 8'h02, 8'h04, 8'h08);
    extra = 1;
    run_frame("extra");

    bus.cs_n = 1'b0;
    wait_clk(5);
    send_byte(HDR);
    send_byte(8'h3C);
    repeat (3) send_bit(1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en", bus.prog_enable, 0);
    chk("arst_data", bus.prog_data, 0);
    chk("arst_valid", bus.prog_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.error, 0);
    model_en = 1'b0;
    last_data = 8'h00;
    bus.cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    good_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    run_frame("postrst");

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) p[i] = 8'($urandom);
      good_frame(p[0], p[1], p[2], p[3]);
      case ($urandom_range(0, 4))
        0: ;
        1: fr[0] = HDR ^ 8'($urandom_range(1, 255));
        2: fr[PB+1] = fr[PB+1] ^ 8'($urandom_range(1, 255));
        3: begin
          fr = fr[0:$urandom_range(0, PB+1)];
          if ($urandom_range(0, 1) == 1) void'(fr.pop_back());
          extra = $urandom_range(0, 7);
        end
        default: if ($urandom_range(0, 1) == 1) extra = $urandom_range(1, 3);
                 else fr.push_back(8'($urandom));
      endcase
      run_frame("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
